// File: rtl/ex_stage_pipe.sv
// Handshaked execute stage: operand-1 select, ALU with zero/overflow flags,
// registered result, and an optional 1-bit-per-cycle serial shifter.
module ex_stage_pipe #(
   parameter int WIDTH        = 16,
   parameter int IMM_W        = 8,
   parameter int SERIAL_SHIFT = 1,
   parameter int SAT          = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [2:0]                 func,
   input  logic [WIDTH-1:0]           src0,
   input  logic [WIDTH-1:0]           p1,
   input  logic [IMM_W-1:0]           imm,
   input  logic                       src1sel,
   input  logic [$clog2(WIDTH)-1:0]   shamt,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [WIDTH-1:0]           dst,
   output logic                       zr,
   output logic                       ov,
   output logic                       busy
);
   localparam int SW = $clog2(WIDTH);

   localparam logic [2:0] F_ADD  = 3'b000;
   localparam logic [2:0] F_SUB  = 3'b001;
   localparam logic [2:0] F_AND  = 3'b010;
   localparam logic [2:0] F_NOR  = 3'b011;
   localparam logic [2:0] F_SLL  = 3'b100;
   localparam logic [2:0] F_SRL  = 3'b101;
   localparam logic [2:0] F_SRA  = 3'b110;

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [1:0]       sop_q, sop_d;
   logic [WIDTH-1:0] dst_q, dst_d;
   logic             zr_q, zr_d;
   logic             ov_q, ov_d;
   logic             vld_q, vld_d;

   logic [WIDTH-1:0] src1;
   logic [WIDTH:0]   add_x, sub_x;
   logic [WIDTH-1:0] res, work_nx;
   logic             res_ov, is_shift, serial_go, accept;

   assign src1  = src1sel ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm} : p1;
   assign add_x = {src0[WIDTH-1], src0} + {src1[WIDTH-1], src1};
   assign sub_x = {src0[WIDTH-1], src0} - {src1[WIDTH-1], src1};

   assign is_shift  = (func == F_SLL) || (func == F_SRL) || (func == F_SRA);
   assign serial_go = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);

   assign busy    = (state_q == SHIFT);
   assign in_rdy  = !busy && (!vld_q || out_rdy);
   assign accept  = in_vld && in_rdy;
   assign out_vld = vld_q;
   assign dst     = dst_q;
   assign zr      = zr_q;
   assign ov      = ov_q;

   // Single-cycle result; the WIDTH+1 sum's top two bits disagree exactly on overflow.
   always_comb begin
      res    = '0;
      res_ov = 1'b0;
      case (func)
         F_ADD: begin
            res    = add_x[WIDTH-1:0];
            res_ov = add_x[WIDTH] ^ add_x[WIDTH-1];
         end
         F_SUB: begin
            res    = sub_x[WIDTH-1:0];
            res_ov = sub_x[WIDTH] ^ sub_x[WIDTH-1];
         end
         F_AND:   res = src0 & src1;
         F_NOR:   res = ~(src0 | src1);
         F_SLL:   res = src0 << shamt;
         F_SRL:   res = src0 >> shamt;
         F_SRA:   res = WIDTH'($signed(src0) >>> shamt);
         default: res = src1;
      endcase
      if ((SAT != 0) && res_ov)
         res = (func == F_ADD ? add_x[WIDTH] : sub_x[WIDTH]) ? SMIN : SMAX;
   end

   // sop_q holds func[1:0]: 00 SLL, 01 SRL, 10 SRA.
   always_comb begin
      case (sop_q)
         2'b00:   work_nx = {work_q[WIDTH-2:0], 1'b0};
         2'b01:   work_nx = {1'b0, work_q[WIDTH-1:1]};
         default: work_nx = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      sop_d   = sop_q;
      dst_d   = dst_q;
      zr_d    = zr_q;
      ov_d    = ov_q;
      vld_d   = vld_q;
      if (flush) begin
         state_d = IDLE;
         vld_d   = 1'b0;
      end else begin
         if (out_rdy) vld_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (serial_go) begin
                     work_d  = src0;
                     cnt_d   = shamt;
                     sop_d   = func[1:0];
                     state_d = SHIFT;
                  end else begin
                     dst_d = res;
                     zr_d  = (res == '0);
                     ov_d  = res_ov;
                     vld_d = 1'b1;
                  end
               end
            end
            default: begin
               work_d = work_nx;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == SW'(1)) begin
                  dst_d   = work_nx;
                  zr_d    = (work_nx == '0);
                  ov_d    = 1'b0;
                  vld_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         sop_q   <= '0;
         dst_q   <= '0;
         zr_q    <= 1'b0;
         ov_q    <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         sop_q   <= sop_d;
         dst_q   <= dst_d;
         zr_q    <= zr_d;
         ov_q    <= ov_d;
         vld_q   <= vld_d;
      end
   end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios plus randomized ops against an
// integer-arithmetic reference; a second instance covers SAT=1 with barrel shifts.
module tb_ex_stage_pipe;
   logic        clk, rst, flush, in_vld, in_rdy, src1sel, out_vld, out_rdy, zr, ov, busy;
   logic [2:0]  func;
   logic [15:0] src0, p1, dst;
   logic [7:0]  imm;
   logic [3:0]  shamt;
   logic        s_in_vld, s_in_rdy, s_out_vld, s_out_rdy, s_zr, s_ov, s_busy;
   logic [15:0] s_dst;

   int checks = 0;
   int errors = 0;

   ex_stage_pipe #(.WIDTH(16), .IMM_W(8), .SERIAL_SHIFT(1), .SAT(0)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
      .func(func), .src0(src0), .p1(p1), .imm(imm), .src1sel(src1sel), .shamt(shamt),
      .out_vld(out_vld), .out_rdy(out_rdy), .dst(dst), .zr(zr), .ov(ov), .busy(busy));

   ex_stage_pipe #(.WIDTH(16), .IMM_W(8), .SERIAL_SHIFT(0), .SAT(1)) u_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_vld(s_in_vld), .in_rdy(s_in_rdy),
      .func(func), .src0(src0), .p1(p1), .imm(imm), .src1sel(src1sel), .shamt(shamt),
      .out_vld(s_out_vld), .out_rdy(s_out_rdy), .dst(s_dst), .zr(s_zr), .ov(s_ov), .busy(s_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns {zr, ov, dst} computed with plain signed integers.
   function automatic logic [17:0] ref_op(input logic [2:0] f, input logic [15:0] a,
                                          input logic [15:0] pr, input logic [7:0] im,
                                          input logic sel, input logic [3:0] sh, input bit sat);
      logic signed [7:0]  sim;
      logic signed [15:0] sa16, sb16;
      int sa, sb, r, ims;
      logic [15:0] b, d;
      logic o;
      sim = im;
      ims = sim;
      b = sel ? ims[15:0] : pr;
      sa16 = a;
      sb16 = b;
      sa = sa16;
      sb = sb16;
      o = 1'b0;
      r = 0;
      case (f)
         3'd0, 3'd1: begin
            r = (f == 3'd0) ? sa + sb : sa - sb;
            o = (r > 32767) || (r < -32768);
            d = r[15:0];
            if (sat && o) d = (r > 0) ? 16'h7FFF : 16'h8000;
         end
         3'd2: d = a & b;
         3'd3: d = ~(a | b);
         3'd4: d = a << sh;
         3'd5: d = a >> sh;
         3'd6: begin r = sa >>> sh; d = r[15:0]; end
         default: d = b;
      endcase
      return {(d == 16'h0), o, d};
   endfunction

   task automatic setop(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] im, input logic sel, input logic [3:0] sh);
      func = f; src0 = a; p1 = b; imm = im; src1sel = sel; shamt = sh;
   endtask

   task automatic issue(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] im, input logic sel, input logic [3:0] sh);
      setop(f, a, b, im, sel, sh);
      in_vld = 1'b1;
      s_in_vld = 1'b1;
      chk("in_rdy_before_issue", 32'(in_rdy), 32'd1);
      tick();
      in_vld = 1'b0;
      s_in_vld = 1'b0;
   endtask

   initial begin
      int seen, lat, explat;
      logic [17:0] r0, r1;
      logic [2:0]  rf;
      logic [3:0]  rsh;
      logic [15:0] ra, rb;
      logic [7:0]  rim;
      logic        rsel;

      rst = 1'b1; flush = 1'b0; in_vld = 1'b0; s_in_vld = 1'b0;
      out_rdy = 1'b1; s_out_rdy = 1'b1;
      setop(3'd0, 16'h0, 16'h0, 8'h0, 1'b0, 4'd0);
      #12;
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_dst", 32'(dst), 32'd0);
      chk("rst_zr", 32'(zr), 32'd0);
      chk("rst_ov", 32'(ov), 32'd0);
      chk("rst_in_rdy", 32'(in_rdy), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_out_vld", 32'(out_vld), 32'd0);

      issue(3'd0, 16'h7FFF, 16'h0001, 8'h00, 1'b0, 4'd0);
      chk("add_ovf_vld", 32'(out_vld), 32'd1);
      chk("add_ovf", {13'd0, zr, ov, dst}, {13'd0, 1'b0, 1'b1, 16'h8000});
      chk("add_ovf_sat", {13'd0, s_zr, s_ov, s_dst}, {13'd0, 1'b0, 1'b1, 16'h7FFF});
      issue(3'd1, 16'h1234, 16'h1234, 8'h00, 1'b0, 4'd0);
      chk("sub_zero", {13'd0, zr, ov, dst}, {13'd0, 1'b1, 1'b0, 16'h0000});
      issue(3'd1, 16'h8000, 16'h0001, 8'h00, 1'b0, 4'd0);
      chk("sub_negovf_sat", {13'd0, s_zr, s_ov, s_dst}, {13'd0, 1'b0, 1'b1, 16'h8000});
      issue(3'd0, 16'h0010, 16'h5555, 8'hFF, 1'b1, 4'd0);
      chk("add_imm_sext", 32'(dst), 32'h000F);
      issue(3'd7, 16'h1111, 16'h2222, 8'h80, 1'b1, 4'd0);
      chk("pass_imm_sext", 32'(dst), 32'hFF80);

      issue(3'd6, 16'h8000, 16'h0, 8'h0, 1'b0, 4'd15);
      chk("sra_barrel_sat_inst", 32'(s_dst), 32'hFFFF);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (busy === 1'b1 && in_rdy === 1'b0 && out_vld === 1'b0) seen++;
         tick();
      end
      chk("sra15_busy_cycles", 32'(seen), 32'd15);
      chk("sra15_done", {14'd0, busy, out_vld, dst}, {14'd0, 1'b0, 1'b1, 16'hFFFF});

      issue(3'd4, 16'h0001, 16'h0, 8'h0, 1'b0, 4'd0);
      chk("sll0", {15'd0, out_vld, dst}, {15'd0, 1'b1, 16'h0001});

      // Four back-to-back ADDs, one result per edge.
      in_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         setop(3'd0, 16'(100 * i), 16'(i + 1), 8'h0, 1'b0, 4'd0);
         chk("b2b_in_rdy", 32'(in_rdy), 32'd1);
         tick();
         chk("b2b_result", {15'd0, out_vld, dst}, {15'd0, 1'b1, 16'(101 * i + 1)});
      end
      in_vld = 1'b0;
      tick();
      chk("b2b_drained", 32'(out_vld), 32'd0);

      out_rdy = 1'b0;
      issue(3'd2, 16'hF0F0, 16'h3C3C, 8'h0, 1'b0, 4'd0);
      setop(3'd3, 16'h00F0, 16'h0F00, 8'h0, 1'b0, 4'd0);
      in_vld = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         if (in_rdy === 1'b0 && out_vld === 1'b1 && dst === 16'h3030) seen++;
         tick();
      end
      chk("hold_stable", 32'(seen), 32'd3);
      out_rdy = 1'b1;
      #1;
      chk("release_in_rdy", 32'(in_rdy), 32'd1);
      tick();
      in_vld = 1'b0;
      chk("drain_and_accept", {15'd0, out_vld, dst}, {15'd0, 1'b1, 16'hF00F});

      // Flush on the third shift edge of an SLL by 10.
      issue(3'd4, 16'h0003, 16'h0, 8'h0, 1'b0, 4'd10);
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_state", {30'd0, busy, out_vld}, 32'd0);
      chk("flush_in_rdy", 32'(in_rdy), 32'd1);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_vld !== 1'b0) seen++;
         tick();
      end
      chk("flush_no_result", 32'(seen), 32'd0);

      setop(3'd7, 16'h0, 16'h1234, 8'h0, 1'b0, 4'd0);
      in_vld = 1'b1;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_vld = 1'b0;
      chk("flush_blocks_accept", 32'(out_vld), 32'd0);

      issue(3'd4, 16'h0003, 16'h0, 8'h0, 1'b0, 4'd10);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_midshift", {29'd0, busy, out_vld, in_rdy}, 32'd1);
      #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_vld !== 1'b0) seen++;
         tick();
      end
      chk("rst_no_result", 32'(seen), 32'd0);

      for (int n = 0; n < 150; n++) begin
         rf   = 3'($urandom_range(0, 7));
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rim  = 8'($urandom);
         rsel = 1'($urandom);
         rsh  = 4'($urandom_range(0, 15));
         if (n % 5 == 0) ra = 16'h7FF0 + 16'($urandom_range(0, 31));
         r0 = ref_op(rf, ra, rb, rim, rsel, rsh, 1'b0);
         r1 = ref_op(rf, ra, rb, rim, rsel, rsh, 1'b1);
         explat = (rf >= 3'd4 && rf <= 3'd6 && rsh != 4'd0) ? int'(rsh) : 0;
         issue(rf, ra, rb, rim, rsel, rsh);
         chk("rand_sat_inst", {13'd0, s_out_vld, s_zr, s_ov, s_dst}, {13'd0, 1'b1, r1});
         lat = 0;
         while (out_vld !== 1'b1 && lat < 40) begin
            tick();
            lat++;
         end
         chk("rand_latency", 32'(lat), 32'(explat));
         chk("rand_result", {14'd0, zr, ov, dst}, {14'd0, r0});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
